// File: rtl/b128to32_ser_if.sv
// Purpose: bundles the 128-bit load side and 32-bit word side of b128to32_ser.
// Latency: none; this is wiring only.
// Backpressure: load/inReady on the block side, outValid/outReady on the word side.
//
// Signals:
//   load      upstream offers dataIn this cycle
//   dataIn    128-bit block, sampled only on load & inReady
//   inReady   serializer can take a block this cycle
//   dataOut   current 32-bit word (0 when outValid = 0)
//   nr        index of the word on dataOut, 0 = bits 127:96 (0 when outValid = 0)
//   outValid  dataOut / nr are valid
//   outReady  downstream takes the word; transfer = outValid & outReady
interface b128to32_ser_if;
    logic         load;
    logic [127:0] dataIn;
    logic         inReady;
    logic [31:0]  dataOut;
    logic [1:0]   nr;
    logic         outValid;
    logic         outReady;

    // master: the side that feeds blocks and consumes words
    modport master (
        output load, dataIn, outReady,
        input  inReady, dataOut, nr, outValid
    );

    // slave: the serializer itself
    modport slave (
        input  load, dataIn, outReady,
        output inReady, dataOut, nr, outValid
    );
endinterface

// File: rtl/b128to32_ser.sv
// Purpose: serializes 128-bit blocks into four 32-bit words, most significant word first.
// Latency: block accepted at edge N shows word nr=0 in the cycle after edge N; 4 cycles per block.
// Backpressure: outReady=0 freezes dataOut/nr; inReady drops while the one-block pending buffer is full.
//
// Ports:
//   clock  rising-edge system clock
//   reset  asynchronous, active-high; discards the current and pending blocks
//   bus    b128to32_ser_if.slave (load/dataIn/inReady in, dataOut/nr/outValid/outReady out)
module b128to32_ser (
    input  logic                 clock,
    input  logic                 reset,
    b128to32_ser_if.slave        bus
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] cur_q,   cur_d;
    logic [1:0]   cnt_q,   cnt_d;
    logic [127:0] pend_q,  pend_d;
    logic         pend_full_q, pend_full_d;

    logic load_acc;
    logic xfer;
    logic last_xfer;

    // inReady depends on registers only, so upstream sees no combinational
    // path from load or outReady.
    assign bus.inReady = ~pend_full_q;
    assign load_acc    = bus.load & ~pend_full_q;
    assign xfer        = (state_q == SEND) & bus.outReady;
    assign last_xfer   = xfer & (cnt_q == 2'd3);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            cnt_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;

        case (state_q)
            IDLE: begin
                if (load_acc) begin
                    cur_d   = bus.dataIn;
                    cnt_d   = 2'd0;
                    state_d = SEND;
                end
            end

            SEND: begin
                if (xfer) begin
                    if (cnt_q != 2'd3) begin
                        cnt_d = cnt_q + 2'd1;
                    end else begin
                        // Last word: refill from pend first, then from a
                        // same-cycle load, otherwise go idle. Either refill
                        // keeps outValid high so nr runs 3 -> 0 with no gap.
                        cnt_d = 2'd0;
                        if (pend_full_q) begin
                            cur_d       = pend_q;
                            pend_full_d = 1'b0;
                        end else if (load_acc) begin
                            cur_d = bus.dataIn;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end

                // A load that was not consumed directly by the last-word
                // refill parks in pend. load_acc already implies pend is
                // empty, so nothing is overwritten.
                if (load_acc && !last_xfer) begin
                    pend_d      = bus.dataIn;
                    pend_full_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Word select; outputs are forced to zero outside SEND.
    always_comb begin
        bus.dataOut  = 32'd0;
        bus.nr       = 2'd0;
        bus.outValid = 1'b0;
        if (state_q == SEND) begin
            bus.outValid = 1'b1;
            bus.nr       = cnt_q;
            case (cnt_q)
                2'd0:    bus.dataOut = cur_q[127:96];
                2'd1:    bus.dataOut = cur_q[95:64];
                2'd2:    bus.dataOut = cur_q[63:32];
                default: bus.dataOut = cur_q[31:0];
            endcase
        end
    end

endmodule

// File: tb/tb_b128to32_ser.sv
module tb_b128to32_ser;

    logic clock;
    logic reset;

    b128to32_ser_if bus ();

    b128to32_ser dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: the words still owed to downstream, in order,
    // each tagged with its index. A block occupies four entries; the pending
    // buffer is full exactly when more than one block's worth is owed.
    logic [33:0] q[$];

    function automatic logic [35:0] exp_vec();
        // {outValid, nr, dataOut, inReady}
        if (q.size() == 0)
            return {1'b0, 2'd0, 32'd0, 1'b1};
        return {1'b1, q[0][33:32], q[0][31:0], (q.size() <= 4)};
    endfunction

    function automatic logic [35:0] obs_vec();
        return {bus.outValid, bus.nr, bus.dataOut, bus.inReady};
    endfunction

    // Drives one cycle from a negedge to the next negedge and advances the model.
    task automatic drive(input logic l, input logic [127:0] d, input logic r, output logic acc);
        logic x;
        acc = l && (q.size() <= 4);
        x   = (q.size() > 0) && r;
        bus.load     = l;
        bus.dataIn   = d;
        bus.outReady = r;
        if (x) void'(q.pop_front());
        if (acc)
            for (int i = 0; i < 4; i++)
                q.push_back({i[1:0], d[127 - 32*i -: 32]});
        @(negedge clock);
    endtask

    function automatic logic [127:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        logic acc;
        reset = 1'b1;
        bus.load = 1'b0; bus.dataIn = '0; bus.outReady = 1'b0;
        @(negedge clock);
        checks++;
        if (obs_vec() !== 36'h0_0000_0001) begin
            failures++;
            $display("FAIL reset_initial got=%h want=%h", obs_vec(), 36'h0_0000_0001);
        end
        reset = 1'b0;
        @(negedge clock);
        // Start a block and send words 0 and 1, then reset mid-cycle.
        drive(1'b1, rand_blk(), 1'b1, acc);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL reset_pre got=%h want=%h", obs_vec(), exp_vec());
            end
            drive(1'b0, '0, 1'b1, acc);
        end
        #1 reset = 1'b1;
        q.delete();
        #1;
        checks++;
        if (obs_vec() !== 36'h0_0000_0001) begin
            failures++;
            $display("FAIL reset_async got=%h want=%h", obs_vec(), 36'h0_0000_0001);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs_vec() !== 36'h0_0000_0001) begin
                failures++;
                $display("FAIL reset_after got=%h want=%h", obs_vec(), 36'h0_0000_0001);
            end
            drive(1'b0, '0, 1'b1, acc);
        end
    endtask

    task automatic test_single();
        logic acc;
        logic [127:0] blk;
        logic [31:0]  w[4];
        blk = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        w[0] = 32'h00112233; w[1] = 32'h44556677; w[2] = 32'h8899AABB; w[3] = 32'hCCDDEEFF;
        drive(1'b1, blk, 1'b1, acc);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.outValid !== 1'b1 || bus.nr !== k[1:0] || bus.dataOut !== w[k]) begin
                failures++;
                $display("FAIL single_word%0d got v=%b nr=%0d d=%h want v=1 nr=%0d d=%h",
                         k, bus.outValid, bus.nr, bus.dataOut, k, w[k]);
            end
            drive(1'b0, '0, 1'b1, acc);
        end
        checks++;
        if (obs_vec() !== 36'h0_0000_0001) begin
            failures++;
            $display("FAIL single_idle got=%h want=%h", obs_vec(), 36'h0_0000_0001);
        end
    endtask

    task automatic test_back_to_back();
        logic acc;
        int   run;
        run = 0;
        drive(1'b1, rand_blk(), 1'b1, acc);
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL b2b_cyc%0d got=%h want=%h", k, obs_vec(), exp_vec());
            end
            if (bus.outValid === 1'b1) run++;
            drive(k == 0, rand_blk(), 1'b1, acc);
        end
        checks++;
        if (run != 8) begin
            failures++;
            $display("FAIL b2b_words got=%0d want=8", run);
        end
    endtask

    task automatic test_same_cycle();
        logic acc;
        drive(1'b1, rand_blk(), 1'b1, acc);
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL samecyc_cyc%0d got=%h want=%h", k, obs_vec(), exp_vec());
            end
            // k == 3 is the cycle where word 3 of the first block transfers
            drive(k == 3, rand_blk(), 1'b1, acc);
            if (k == 3) begin
                checks++;
                if (acc !== 1'b1 || bus.nr !== 2'd0 || bus.outValid !== 1'b1) begin
                    failures++;
                    $display("FAIL samecyc_restart got v=%b nr=%0d want v=1 nr=0",
                             bus.outValid, bus.nr);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic acc;
        logic [31:0] held;
        drive(1'b1, rand_blk(), 1'b1, acc);
        drive(1'b0, '0, 1'b1, acc);
        drive(1'b0, '0, 1'b1, acc);
        held = bus.dataOut;
        for (int k = 0; k < 11; k++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL bp_cyc%0d got=%h want=%h", k, obs_vec(), exp_vec());
            end
            if (k < 5) begin
                checks++;
                if (bus.nr !== 2'd2 || bus.dataOut !== held) begin
                    failures++;
                    $display("FAIL bp_hold got nr=%0d d=%h want nr=2 d=%h", bus.nr, bus.dataOut, held);
                end
            end
            drive(1'b0, '0, k >= 5, acc);
        end
    endtask

    task automatic test_full_hold();
        logic acc;
        logic [127:0] d;
        int waited;
        drive(1'b1, rand_blk(), 1'b1, acc);
        drive(1'b1, rand_blk(), 1'b1, acc);
        d = rand_blk();
        acc = 1'b0;
        waited = 0;
        while (!acc && waited < 20) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL hold_cyc%0d got=%h want=%h", waited, obs_vec(), exp_vec());
            end
            drive(1'b1, d, 1'b1, acc);
            waited++;
        end
        // A is sent over 4 cycles; D gets in on the cycle after A3.
        checks++;
        if (waited != 4) begin
            failures++;
            $display("FAIL hold_wait got=%0d want=4", waited);
        end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL hold_drain%0d got=%h want=%h", k, obs_vec(), exp_vec());
            end
            drive(1'b0, '0, 1'b1, acc);
        end
    endtask

    task automatic test_random();
        logic acc;
        logic pl;
        logic [127:0] pd;
        int bad;
        pl = 1'b0; pd = '0; bad = 0;
        for (int k = 0; k < 3000; k++) begin
            if (obs_vec() !== exp_vec()) begin
                if (bad < 5)
                    $display("FAIL random_cyc%0d got=%h want=%h", k, obs_vec(), exp_vec());
                bad++;
            end
            if (!pl && ($urandom_range(0, 2) != 0)) begin
                pl = 1'b1;
                pd = rand_blk();
            end
            drive(pl, pd, $urandom_range(0, 3) != 0, acc);
            if (acc) pl = 1'b0;
        end
        for (int k = 0; k < 40 && q.size() > 0; k++)
            drive(1'b0, '0, 1'b1, acc);
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL random_mismatches got=%0d want=0", bad);
        end
        checks++;
        if (obs_vec() !== exp_vec() || q.size() != 0) begin
            failures++;
            $display("FAIL random_drain got=%h want=%h left=%0d", obs_vec(), exp_vec(), q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_same_cycle();
        test_backpressure();
        test_full_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
